ds_capture_ctrl: RTL

DS_CAPTURE_CTRL -- requirements
Module: ds_capture_ctrl

---
 rtl/ds_capture_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ds_capture_ctrl.sv
// Capture controller: gates a decimating filter chain, discards settle samples, buffers captured samples in a FIFO.
// Optional per-entry sample tag storage enabled by defining DS_CAPTURE_TAG_EN.
module ds_capture_ctrl #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               settle_cnt,
    input  logic [15:0]              num_samples,
    output logic                     filter_enable,
    input  logic                     flt_ce,
    input  logic [DW-1:0]            flt_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic [7:0]               rd_tag,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
`ifdef DS_CAPTURE_TAG_EN
    localparam int EW = DW + 8;
`else
    localparam int EW = DW;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_DONE} state_t;
    state_t state_q, state_d;

    logic [7:0]    settle_tgt_q, settle_tgt_d, settle_q, settle_d;
    logic [15:0]   num_q, num_d, sample_q, sample_d;
    logic          filter_enable_q, filter_enable_d, overflow_q, overflow_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] wr_entry;

    logic start_acc, settle_ce, cap_ce, last_sample, pop, push, full;

    always_comb begin
        start_acc   = (state_q == S_IDLE) && start;
        settle_ce   = (state_q == S_SETTLE) && flt_ce && !abort;
        cap_ce      = (state_q == S_CAPTURE) && flt_ce && !abort;
        last_sample = (num_q != 16'd0) && ((sample_q + 16'd1) == num_q);
        full        = (level_q == LVL_FULL);
        pop         = rd_en && (level_q != '0);
        // When full, a same-cycle pop frees the slot the push lands in.
        push        = cap_ce && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = (settle_cnt != 8'd0) ? S_SETTLE : S_CAPTURE;
            S_SETTLE: begin
                if (abort) state_d = S_IDLE;
                else if (flt_ce && (settle_q == settle_tgt_q - 8'd1)) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (abort) state_d = S_IDLE;
                else if (flt_ce && last_sample) state_d = S_DONE;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
        done          = (state_q == S_DONE);
        filter_enable = filter_enable_q;
        overflow      = overflow_q;
        level         = level_q;
        rd_data       = rd_data_q;
        rd_valid      = rd_valid_q;
    end

    always_comb begin
        settle_tgt_d    = settle_tgt_q;
        settle_d        = settle_q;
        num_d           = num_q;
        sample_d        = sample_q;
        overflow_d      = overflow_q;
        filter_enable_d = (state_d == S_SETTLE) || (state_d == S_CAPTURE);
        if (start_acc) begin
            settle_tgt_d = settle_cnt;
            num_d        = num_samples;
            settle_d     = 8'd0;
            sample_d     = 16'd0;
            overflow_d   = 1'b0;
        end
        if (settle_ce) settle_d = settle_q + 8'd1;
        if (cap_ce) begin
            sample_d = sample_q + 16'd1;
            if (full && !pop) overflow_d = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (!push && pop) level_d = level_q - 1'b1;
        rd_valid_d = pop;
        rd_data_d  = pop ? mem_q[rd_ptr_q][DW-1:0] : rd_data_q;
`ifdef DS_CAPTURE_TAG_EN
        wr_entry = {sample_q[7:0], flt_data};
`else
        wr_entry = flt_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_tgt_q    <= '0;
            settle_q        <= '0;
            num_q           <= '0;
            sample_q        <= '0;
            filter_enable_q <= 1'b0;
            overflow_q      <= 1'b0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            rd_data_q       <= '0;
            rd_valid_q      <= 1'b0;
        end else begin
            settle_tgt_q    <= settle_tgt_d;
            settle_q        <= settle_d;
            num_q           <= num_d;
            sample_q        <= sample_d;
            filter_enable_q <= filter_enable_d;
            overflow_q      <= overflow_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            rd_data_q       <= rd_data_d;
            rd_valid_q      <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= wr_entry;
    end

`ifdef DS_CAPTURE_TAG_EN
    logic [7:0] rd_tag_q, rd_tag_d;
    always_comb rd_tag_d = pop ? mem_q[rd_ptr_q][EW-1:DW] : rd_tag_q;
    always_ff @(posedge clk) begin
        if (reset) rd_tag_q <= 8'd0;
        else       rd_tag_q <= rd_tag_d;
    end
    assign rd_tag = rd_tag_q;
`else
    assign rd_tag = 8'd0;
`endif

endmodule
